tx_hash_framer: RTL and testbench

- Transmit-side counterpart of the receive hash/classify path.
- Accepts one header descriptor per packet (dest IP/port, src IP/port, flow hash, hash type) and a 256-bit AXI-stream payload.
- Emits a framed AXI-stream: one 256-bit header beat built from the descriptor, followed by the payload beats passed through unchanged.
- Sits between the TX queue/scheduler and the MAC-side TX pipeline; adds a 16-bit frame sequence number and frame/beat statistics.

---
 rtl/tx_hash_framer.sv | 113 +++++++++++
 tb/tb_tx_hash_framer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_hash_framer.sv
// TX framer: prepends a 256-bit descriptor header beat to each payload packet
// and counts completed frames. All m_axis outputs come from one register stage.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a header descriptor; payload input held off
// PAYLOAD | header emitted; passing payload beats until tlast accepted
module tx_hash_framer #(
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  s_hdr_valid,
    output logic                  s_hdr_ready,
    input  logic [31:0]           s_hdr_dest_ip,
    input  logic [15:0]           s_hdr_dest_port,
    input  logic [31:0]           s_hdr_src_ip,
    input  logic [15:0]           s_hdr_src_port,
    input  logic [31:0]           s_hdr_hash,
    input  logic [3:0]            s_hdr_hash_type,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,

    output logic [31:0]           frame_count,
    output logic                  busy
);

    typedef enum logic {
        IDLE,
        PAYLOAD
    } state_t;

    state_t                state;
    logic [15:0]           seq;
    logic [DATA_WIDTH-1:0] hdr_beat;
    logic                  ld;
    logic                  hdr_fire;
    logic                  pay_fire;

    // Output register can take a new beat when empty or being drained this cycle.
    assign ld = !m_axis_tvalid || m_axis_tready;

    // Readies are gated by rst so nothing looks accepted while in reset.
    assign s_hdr_ready   = !rst && (state == IDLE) && ld;
    assign s_axis_tready = !rst && (state == PAYLOAD) && ld;

    assign hdr_fire = s_hdr_valid && s_hdr_ready;
    assign pay_fire = s_axis_tvalid && s_axis_tready;

    assign busy = (state == PAYLOAD) || m_axis_tvalid;

    always_comb begin
        hdr_beat           = '0;
        hdr_beat[31:0]     = s_hdr_dest_ip;
        hdr_beat[47:32]    = s_hdr_dest_port;
        hdr_beat[63:48]    = s_hdr_src_port;
        hdr_beat[95:64]    = s_hdr_src_ip;
        hdr_beat[127:96]   = s_hdr_hash;
        hdr_beat[131:128]  = s_hdr_hash_type;
        hdr_beat[151:136]  = seq;
        hdr_beat[159:152]  = 8'hA5;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            seq           <= 16'd0;
            frame_count   <= 32'd0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                frame_count <= frame_count + 32'd1;
            end

            if (ld) begin
                if (hdr_fire) begin
                    m_axis_tdata  <= hdr_beat;
                    m_axis_tkeep  <= '1;
                    m_axis_tlast  <= 1'b0;
                    m_axis_tvalid <= 1'b1;
                    seq           <= seq + 16'd1;
                    state         <= PAYLOAD;
                end else if (pay_fire) begin
                    m_axis_tdata  <= s_axis_tdata;
                    m_axis_tkeep  <= s_axis_tkeep;
                    m_axis_tlast  <= s_axis_tlast;
                    m_axis_tvalid <= 1'b1;
                    if (s_axis_tlast) begin
                        state <= IDLE;
                    end
                end else begin
                    m_axis_tvalid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_hash_framer.sv
// Scoreboard bench for tx_hash_framer: drivers feed header/payload queues,
// a negedge monitor pops expected beats on every output handshake.
module tb_tx_hash_framer;

    localparam int DW = 256;
    localparam int KW = 32;

    typedef struct packed {
        logic [31:0] dip;
        logic [15:0] dport;
        logic [31:0] sip;
        logic [15:0] sport;
        logic [31:0] hash;
        logic [3:0]  htype;
    } hdr_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_hdr_valid;
    logic          s_hdr_ready;
    logic [31:0]   s_hdr_dest_ip;
    logic [15:0]   s_hdr_dest_port;
    logic [31:0]   s_hdr_src_ip;
    logic [15:0]   s_hdr_src_port;
    logic [31:0]   s_hdr_hash;
    logic [3:0]    s_hdr_hash_type;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [31:0]   frame_count;
    logic          busy;

    always #5 clk = ~clk;

    tx_hash_framer #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
        .clk(clk), .rst(rst),
        .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
        .s_hdr_dest_ip(s_hdr_dest_ip), .s_hdr_dest_port(s_hdr_dest_port),
        .s_hdr_src_ip(s_hdr_src_ip), .s_hdr_src_port(s_hdr_src_port),
        .s_hdr_hash(s_hdr_hash), .s_hdr_hash_type(s_hdr_hash_type),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .frame_count(frame_count), .busy(busy)
    );

    hdr_t  hq[$];
    beat_t pq[$];
    beat_t sb[$];
    int    total = 0;
    int    passed = 0;
    int    run_len = 0;
    int    max_run = 0;
    logic  bp_en = 1'b0;
    logic [3:0] bp_pat = 4'b1001;
    int    bp_idx = 0;
    logic  stall_prev = 1'b0;
    logic [DW-1:0] stall_data;

    localparam logic [DW-1:0] AA  = {32{8'hAA}};
    localparam logic [DW-1:0] PNG = {4{64'h89504E470D0A1A0A}};
    localparam logic [DW-1:0] H1  = 256'hA5000001_DEADBEEF_0A000001_1F900016_C0A80001;
    localparam logic [DW-1:0] H2  = 256'hA5000101_DEADBEEF_0A000001_1F900015_C0A80001;
    localparam logic [DW-1:0] H3  = 256'hA500020F_11223344_05060708_ABCD1234_01020304;
    localparam logic [DW-1:0] H4  = 256'hA5000302_CAFEF00D_0B0B0B0B_C3500050_0A0A0A0A;
    localparam logic [DW-1:0] H5  = 256'hA5000403_5A5A5A5A_7F000002_00020001_7F000001;
    localparam logic [DW-1:0] H6  = 256'hA5000501_DEADBEEF_0A000001_1F900016_C0A80001;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic beat_t mk(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        return b;
    endfunction

    function automatic hdr_t mkh(input logic [31:0] dip, input logic [15:0] dport,
                                 input logic [31:0] sip, input logic [15:0] sport,
                                 input logic [31:0] hash, input logic [3:0] htype);
        hdr_t h;
        h.dip = dip; h.dport = dport; h.sip = sip;
        h.sport = sport; h.hash = hash; h.htype = htype;
        return h;
    endfunction

    task automatic push_hdr(input hdr_t h, input logic [DW-1:0] hexp);
        hq.push_back(h);
        sb.push_back(mk(hexp, '1, 1'b0));
    endtask

    task automatic push_beat(input beat_t b);
        pq.push_back(b);
        sb.push_back(b);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((hq.size() != 0 || pq.size() != 0 || sb.size() != 0 || m_axis_tvalid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n < 2000) passed++;
        else $display("FAIL %s: drain timeout, %0d beats still expected", name, sb.size());
    endtask

    // Header driver
    initial begin
        logic f;
        s_hdr_valid = 1'b0;
        {s_hdr_dest_ip, s_hdr_dest_port, s_hdr_src_ip, s_hdr_src_port, s_hdr_hash, s_hdr_hash_type} = '0;
        forever begin
            @(negedge clk);
            f = s_hdr_valid && s_hdr_ready;
            @(posedge clk);
            #1;
            if (f) void'(hq.pop_front());
            if (hq.size() != 0) begin
                s_hdr_valid = 1'b1;
                {s_hdr_dest_ip, s_hdr_dest_port, s_hdr_src_ip, s_hdr_src_port, s_hdr_hash, s_hdr_hash_type} = hq[0];
            end else begin
                s_hdr_valid = 1'b0;
            end
        end
    end

    // Payload driver
    initial begin
        logic f;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        s_axis_tkeep = '0;
        s_axis_tlast = 1'b0;
        forever begin
            @(negedge clk);
            f = s_axis_tvalid && s_axis_tready;
            @(posedge clk);
            #1;
            if (f) void'(pq.pop_front());
            if (pq.size() != 0) begin
                s_axis_tvalid = 1'b1;
                {s_axis_tdata, s_axis_tkeep, s_axis_tlast} = pq[0];
            end else begin
                s_axis_tvalid = 1'b0;
            end
        end
    end

    // Downstream ready, optionally following a 1,0,0,1 pattern
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                m_axis_tready = bp_pat[bp_idx];
                bp_idx = (bp_idx + 1) % 4;
            end else begin
                m_axis_tready = 1'b1;
            end
        end
    end

    // Monitor: stability under stall plus scoreboard compare on handshake
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            run_len = 0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid_held", DW'(m_axis_tvalid), DW'(1'b1));
                chk("stall_data_held", m_axis_tdata, stall_data);
            end
            if (m_axis_tvalid && !m_axis_tready) begin
                chk("stall_s_tready", DW'(s_axis_tready), DW'(1'b0));
                stall_prev = 1'b1;
                stall_data = m_axis_tdata;
            end else begin
                stall_prev = 1'b0;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_beat: got %0h expected none", m_axis_tdata);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("beat_data", m_axis_tdata, e.data);
                    chk("beat_keep", DW'(m_axis_tkeep), DW'(e.keep));
                    chk("beat_last", DW'(m_axis_tlast), DW'(e.last));
                end
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hdr_ready", DW'(s_hdr_ready), DW'(1'b0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_hdr_ready", DW'(s_hdr_ready), DW'(1'b1));
        chk("post_rst_tvalid", DW'(m_axis_tvalid), DW'(1'b0));
        chk("post_rst_s_tready", DW'(s_axis_tready), DW'(1'b0));
        chk("post_rst_busy", DW'(busy), DW'(1'b0));
        chk("post_rst_frames", DW'(frame_count), DW'(0));

        // 1: basic frame
        @(posedge clk); #1;
        max_run = 0;
        push_hdr(mkh(32'hC0A80001, 16'h0016, 32'h0A000001, 16'h1F90, 32'hDEADBEEF, 4'h1), H1);
        push_beat(mk(AA, '1, 1'b0));
        push_beat(mk(PNG, '1, 1'b0));
        push_beat(mk(AA, '1, 1'b1));
        wait_drain("t1_drain");
        chk("t1_frames", DW'(frame_count), DW'(1));
        chk("t1_run", DW'(max_run), DW'(4));

        // 2: back-to-back frames, second header stalls during first payload
        @(posedge clk); #1;
        max_run = 0;
        push_hdr(mkh(32'hC0A80001, 16'h0016, 32'h0A000001, 16'h1F90, 32'hDEADBEEF, 4'h1), 256'hA5000101_DEADBEEF_0A000001_1F900016_C0A80001);
        push_beat(mk(PNG, '1, 1'b0));
        push_beat(mk(AA, '1, 1'b1));
        push_hdr(mkh(32'hC0A80001, 16'h0015, 32'h0A000001, 16'h1F90, 32'hDEADBEEF, 4'h1), 256'hA5000201_DEADBEEF_0A000001_1F900015_C0A80001);
        push_beat(mk(AA, '1, 1'b0));
        push_beat(mk(PNG, '1, 1'b1));
        wait_drain("t2_drain");
        chk("t2_frames", DW'(frame_count), DW'(3));
        chk("t2_no_gap_run", DW'(max_run), DW'(6));

        // Reset so the remaining headers carry the seq values hand-computed above
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t2_rst_frames", DW'(frame_count), DW'(0));
        @(posedge clk); #1;
        push_hdr(mkh(32'hC0A80001, 16'h0016, 32'h0A000001, 16'h1F90, 32'hDEADBEEF, 4'h1), H1);
        push_beat(mk(AA, '1, 1'b1));
        push_hdr(mkh(32'hC0A80001, 16'h0015, 32'h0A000001, 16'h1F90, 32'hDEADBEEF, 4'h1), H2);
        push_beat(mk(PNG, '1, 1'b1));
        wait_drain("t2b_drain");
        chk("t2b_frames", DW'(frame_count), DW'(2));

        // 3: backpressure 1,0,0,1 on m_axis_tready
        @(posedge clk); #1;
        bp_idx = 0;
        bp_en = 1'b1;
        push_hdr(mkh(32'h01020304, 16'h1234, 32'h05060708, 16'hABCD, 32'h11223344, 4'hF), H3);
        push_beat(mk({8{32'h0000_0001}}, '1, 1'b0));
        push_beat(mk({8{32'h0000_0002}}, '1, 1'b0));
        push_beat(mk({8{32'h0000_0003}}, '1, 1'b0));
        push_beat(mk({8{32'h0000_0004}}, '1, 1'b1));
        wait_drain("t3_drain");
        bp_en = 1'b0;
        chk("t3_frames", DW'(frame_count), DW'(3));

        // 4: payload presented before its header
        @(posedge clk); #1;
        sb.push_back(mk(H4, '1, 1'b0));
        push_beat(mk({16{16'hBEEF}}, '1, 1'b0));
        push_beat(mk({16{16'hF00D}}, '1, 1'b1));
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_s_tready_held", DW'(s_axis_tready), DW'(1'b0));
            chk("t4_no_output", DW'(m_axis_tvalid), DW'(1'b0));
        end
        @(posedge clk); #1;
        hq.push_back(mkh(32'h0A0A0A0A, 16'h0050, 32'h0B0B0B0B, 16'hC350, 32'hCAFEF00D, 4'h2));
        wait_drain("t4_drain");
        chk("t4_frames", DW'(frame_count), DW'(4));

        // 5: single-beat payload with partial keep
        @(posedge clk); #1;
        push_hdr(mkh(32'h7F000001, 16'h0001, 32'h7F000002, 16'h0002, 32'h5A5A5A5A, 4'h3), H5);
        push_beat(mk({32{8'h5C}}, 32'h0000FFFF, 1'b1));
        wait_drain("t5_drain");
        chk("t5_frames", DW'(frame_count), DW'(5));

        // 6: reset mid-frame
        @(posedge clk); #1;
        push_hdr(mkh(32'hC0A80001, 16'h0016, 32'h0A000001, 16'h1F90, 32'hDEADBEEF, 4'h1), H6);
        push_beat(mk(AA, '1, 1'b0));
        wait_drain("t6_partial_drain");
        chk("t6_busy_mid", DW'(busy), DW'(1'b1));
        chk("t6_hdr_ready_mid", DW'(s_hdr_ready), DW'(1'b0));
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("t6_hdr_ready_in_rst", DW'(s_hdr_ready), DW'(1'b0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_tvalid", DW'(m_axis_tvalid), DW'(1'b0));
        chk("t6_busy", DW'(busy), DW'(1'b0));
        chk("t6_frames", DW'(frame_count), DW'(0));
        chk("t6_hdr_ready", DW'(s_hdr_ready), DW'(1'b1));
        @(posedge clk); #1;
        push_hdr(mkh(32'hC0A80001, 16'h0016, 32'h0A000001, 16'h1F90, 32'hDEADBEEF, 4'h1), H1);
        push_beat(mk(PNG, '1, 1'b1));
        wait_drain("t6_next_drain");
        chk("t6_next_frames", DW'(frame_count), DW'(1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
